// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load clamping helper.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    // Nibbles above 9 are not valid BCD; pin them to the top digit value.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with explicit 9<->0 rollover and a look-ahead roll flag.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       roll
);

    bcd_digit_t cnt;

    // roll tells the next-higher digit that this digit's next step wraps.
    assign roll = up ? (cnt == BCD_MAX) : (cnt == BCD_MIN);
    assign q    = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= BCD_MIN;
        end else if (load) begin
            cnt <= bcd_clamp(load_val);
        end else if (step) begin
            if (up)
                cnt <= roll ? BCD_MIN : cnt + 4'd1;
            else
                cnt <= roll ? BCD_MAX : cnt - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter (00-99) with prescaler, load, tick and carry pulses.
// Build option: define BCD_COUNTER_SATURATE_EN to hold at 99/00 instead of wrapping.
module bcd_counter_2d
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] bcd_hi,
    output logic [3:0] bcd_lo,
    output logic       tick,
    output logic       carry
);

    localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PC_W-1:0] PC_TOP = PC_W'(TICK_DIV - 1);

    logic [PC_W-1:0] pc;
    logic            at_top;
    logic            step_edge;
    logic            lo_roll;
    logic            hi_roll;
    logic            at_limit;
    logic            lo_step;
    logic            hi_step;

    assign at_top    = (pc == PC_TOP);
    assign step_edge = en && !load && at_top;
    // Both digits rolling together means the counter sits at 99 (up) or 00 (down).
    assign at_limit  = lo_roll && hi_roll;

`ifdef BCD_COUNTER_SATURATE_EN
    assign lo_step = step_edge && !at_limit;
`else
    assign lo_step = step_edge;
`endif
    assign hi_step = lo_step && lo_roll;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            pc <= '0;
        end else if (en) begin
            pc <= at_top ? '0 : pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || load) begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end else begin
            tick  <= step_edge;
            carry <= step_edge && at_limit;
        end
    end

    bcd_digit u_lo (
        .clk      (clk),
        .reset    (reset),
        .step     (lo_step),
        .up       (up),
        .load     (load),
        .load_val (load_val[3:0]),
        .q        (bcd_lo),
        .roll     (lo_roll)
    );

    bcd_digit u_hi (
        .clk      (clk),
        .reset    (reset),
        .step     (hi_step),
        .up       (up),
        .load     (load),
        .load_val (load_val[7:4]),
        .q        (bcd_hi),
        .roll     (hi_roll)
    );

endmodule

// File: tb/tb_bcd_counter_2d.sv
// Directed bench for bcd_counter_2d with TICK_DIV=4; expectations are hand-computed.
module tb_bcd_counter_2d;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] bcd_hi;
    logic [3:0] bcd_lo;
    logic       tick;
    logic       carry;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_counter_2d #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bcd_hi   (bcd_hi),
        .bcd_lo   (bcd_lo),
        .tick     (tick),
        .carry    (carry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        edges(1);
        load     = 1'b0;
    endtask

    function automatic logic [7:0] bcd();
        return {bcd_hi, bcd_lo};
    endfunction

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        edges(2);
        check("reset_bcd",   32'(bcd()), 32'h00);
        check("reset_tick",  32'(tick),  32'd0);
        check("reset_carry", 32'(carry), 32'd0);

        // 1: first step exactly 4 edges after reset drops, then every 4
        reset = 1'b0; en = 1'b1; up = 1'b1;
        edges(3);
        check("pre_step_bcd",  32'(bcd()), 32'h00);
        check("pre_step_tick", 32'(tick),  32'd0);
        edges(1);
        check("step1_bcd",  32'(bcd()), 32'h01);
        check("step1_tick", 32'(tick),  32'd1);
        edges(1);
        check("step1_tick_low", 32'(tick), 32'd0);
        edges(2);
        check("step2_pre_tick", 32'(tick), 32'd0);
        edges(1);
        check("step2_bcd",  32'(bcd()), 32'h02);
        check("step2_tick", 32'(tick),  32'd1);

        // 2: decade and wrap up
        do_load(8'h09);
        check("load09_bcd",  32'(bcd()), 32'h09);
        check("load09_tick", 32'(tick),  32'd0);
        edges(4);
        check("decade_bcd",   32'(bcd()), 32'h10);
        check("decade_carry", 32'(carry), 32'd0);
        do_load(8'h99);
        edges(4);
`ifdef BCD_COUNTER_SATURATE_EN
        check("wrap_up_bcd", 32'(bcd()), 32'h99);
`else
        check("wrap_up_bcd", 32'(bcd()), 32'h00);
`endif
        check("wrap_up_carry", 32'(carry), 32'd1);
        check("wrap_up_tick",  32'(tick),  32'd1);
        edges(1);
        check("wrap_up_carry_low", 32'(carry), 32'd0);

        // 3: down wrap
        up = 1'b0;
        do_load(8'h10);
        edges(4);
        check("down_decade_bcd",   32'(bcd()), 32'h09);
        check("down_decade_carry", 32'(carry), 32'd0);
        do_load(8'h00);
        edges(4);
`ifdef BCD_COUNTER_SATURATE_EN
        check("wrap_down_bcd", 32'(bcd()), 32'h00);
`else
        check("wrap_down_bcd", 32'(bcd()), 32'h99);
`endif
        check("wrap_down_carry", 32'(carry), 32'd1);

        // 4: load clamping, prescaler restarts
        up = 1'b1;
        do_load(8'hAF);
        check("clamp_bcd", 32'(bcd()), 32'h99);
        edges(3);
        check("clamp_hold_bcd",  32'(bcd()), 32'h99);
        check("clamp_hold_tick", 32'(tick),  32'd0);
        edges(1);
        check("clamp_step_tick", 32'(tick), 32'd1);
`ifdef BCD_COUNTER_SATURATE_EN
        check("clamp_step_bcd", 32'(bcd()), 32'h99);
`else
        check("clamp_step_bcd", 32'(bcd()), 32'h00);
`endif

        // 5: load on a step edge wins; reset beats load
        do_load(8'h05);
        edges(3);
        do_load(8'h42);
        check("load_on_step_bcd",  32'(bcd()), 32'h42);
        check("load_on_step_tick", 32'(tick),  32'd0);
        edges(3);
        reset = 1'b1; load = 1'b1; load_val = 8'h77;
        edges(1);
        check("reset_load_bcd",  32'(bcd()), 32'h00);
        check("reset_load_tick", 32'(tick),  32'd0);
        reset = 1'b0; load = 1'b0;

        // 6: enable gating mid-prescale
        edges(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            check("disabled_tick", 32'(tick), 32'd0);
        end
        check("disabled_bcd", 32'(bcd()), 32'h00);
        en = 1'b1;
        edges(1);
        check("reenable1_tick", 32'(tick),  32'd0);
        check("reenable1_bcd",  32'(bcd()), 32'h00);
        edges(1);
        check("reenable2_tick", 32'(tick),  32'd1);
        check("reenable2_bcd",  32'(bcd()), 32'h01);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
